jtpang_objdma: RTL and testbench

- Sprite-table DMA engine and double-buffered object RAM. Sits upstream of the object line scanner.
- On a CPU trigger it requests the Z80 bus and sweeps the VRAM sprite area. It copies each byte into the back bank of an internal 2-bank buffer.
- It swaps banks at the next vertical sync, so the scanner never reads a half-written table.

---
 rtl/jtpang_objdma.sv | 116 +++++++++++
 tb/tb_jtpang_objdma.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpang_objdma.sv
// Sprite-table DMA: copies VRAM 0..LAST into the back bank of a double-buffered
// object RAM while holding the Z80 bus, then flips banks on the next vsync edge.
module jtpang_objdma #(
  parameter int unsigned   AW   = 9,
  parameter logic [AW-1:0] LAST = 9'd511
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          vs,
  input  logic          dma_go,
  output logic          busrq,
  input  logic          busak_n,
  output logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  input  logic [AW-1:0] scan_addr,
  output logic [7:0]    scan_dout,
  output logic          busy,
  output logic          bank
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] COPY  = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    state;
  logic          pending;
  logic          swap_req;
  logic          vs_l;
  logic          vs_rise;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic          ram_we;

  logic [7:0] mem [0:2**(AW+1)-1];

  always_comb begin
    vs_rise = vs & ~vs_l;
    ram_we  = cen & wr_valid & (((state == COPY) & ~busak_n) | (state == FLUSH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busrq    <= 1'b0;
      busy     <= 1'b0;
      dma_addr <= '0;
      bank     <= 1'b0;
      pending  <= 1'b0;
      swap_req <= 1'b0;
      vs_l     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
    end else begin
      vs_l <= vs;
      // dma_go is sampled on every clk so a pulse between cens is kept
      if (cen && state == IDLE) pending <= 1'b0;
      else if (dma_go)          pending <= 1'b1;
      if (vs_rise && swap_req) begin
        bank     <= ~bank;
        swap_req <= 1'b0;
      end
      if (cen) begin
        case (state)
          IDLE: begin
            if (dma_go || pending) begin
              state    <= REQ;
              busrq    <= 1'b1;
              busy     <= 1'b1;
              dma_addr <= '0;
              wr_valid <= 1'b0;
            end
          end
          REQ: begin
            if (!busak_n) state <= COPY;
          end
          COPY: begin
            if (busak_n) begin
              // Bus lost: drop the in-flight byte and rewind so it is read again
              if (wr_valid) dma_addr <= wr_addr;
              wr_valid <= 1'b0;
            end else begin
              wr_addr  <= dma_addr;
              wr_valid <= 1'b1;
              if (dma_addr == LAST) state <= FLUSH;
              else                  dma_addr <= dma_addr + 1'b1;
            end
          end
          FLUSH: begin
            wr_valid <= 1'b0;
            state    <= DONE;
          end
          DONE: begin
            busrq    <= 1'b0;
            busy     <= 1'b0;
            swap_req <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[{~bank, wr_addr}] <= dma_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) scan_dout <= 8'd0;
    else     scan_dout <= mem[{bank, scan_addr}];
  end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: VRAM and bus-ack models plus a table-level model of
// both object RAM banks and the expected front bank.
module tb_jtpang_objdma;

  localparam int N = 512;

  logic       clk = 1'b0, rst = 1'b1, cen = 1'b0, vs = 1'b0, dma_go = 1'b0;
  logic       busrq, busak_n, busy, bank;
  logic [8:0] dma_addr;
  logic [8:0] scan_addr = '0;
  logic [7:0] dma_din = 8'd0, scan_dout;

  logic       ack_hold = 1'b0, d1 = 1'b0, d2 = 1'b0;
  logic [7:0] vram [N];
  logic [7:0] exp_mem [2][N];
  logic       exp_bank = 1'b0;
  int         errors = 0, checks = 0, cen_cnt = 0;

  jtpang_objdma dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .vs        (vs),
    .dma_go    (dma_go),
    .busrq     (busrq),
    .busak_n   (busak_n),
    .dma_addr  (dma_addr),
    .dma_din   (dma_din),
    .scan_addr (scan_addr),
    .scan_dout (scan_dout),
    .busy      (busy),
    .bank      (bank)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cen_cnt = (cen_cnt == 5) ? 0 : cen_cnt + 1;
    cen     = (cen_cnt == 0);
  end

  // CPU acks two cens after the request; VRAM returns garbage without the bus
  assign busak_n = ack_hold | ~d2;
  always @(posedge clk) begin
    if (cen) begin
      d1      <= busrq;
      d2      <= d1;
      dma_din <= busak_n ? 8'($urandom) : vram[dma_addr];
    end
  end

  task automatic tick_cen();
    do @(posedge clk); while (!cen);
    #1;
  endtask

  task automatic pulse_go();
    @(negedge clk); dma_go = 1'b1;
    @(negedge clk); dma_go = 1'b0;
  endtask

  task automatic pulse_vs();
    @(negedge clk); vs = 1'b1;
    repeat (3) @(negedge clk);
    vs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic read_scan(input logic [8:0] a, output logic [7:0] d);
    @(negedge clk); scan_addr = a;
    @(posedge clk); #1;
    d = scan_dout;
  endtask

  task automatic fill_vram(input bit rnd);
    for (int a = 0; a < N; a++) vram[a] = rnd ? 8'($urandom) : (8'(a) ^ 8'h5A);
  endtask

  // A finished copy replaces the whole back bank with the VRAM table
  task automatic commit();
    for (int a = 0; a < N; a++) exp_mem[exp_bank ? 0 : 1][a] = vram[a];
  endtask

  task automatic wait_idle(output bit ok);
    bit seen = 0;
    ok = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (busy) seen = 1;
      else tick_cen();
    end
    for (int i = 0; i < 3000 && seen; i++) begin
      tick_cen();
      if (!busrq && !busy) begin ok = 1; break; end
    end
  endtask

  task automatic wait_addr(input logic [8:0] target, output bit found);
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      tick_cen();
      if (dma_addr >= target && busrq) begin found = 1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busrq !== 1'b0) $display("FAIL reset_busrq: got %b expected 0", busrq);
    if (busrq !== 1'b0) errors++;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (dma_addr !== 9'd0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", dma_addr); end
    checks++; if (bank !== 1'b0) begin errors++; $display("FAIL reset_bank: got %b expected 0", bank); end
    checks++; if (scan_dout !== 8'd0) begin errors++; $display("FAIL reset_scan: got %0h expected 0", scan_dout); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    logic ak; bit acked = 0; int cnt = 0, bad = 0; logic [7:0] d;
    fill_vram(0);
    pulse_go();
    for (int i = 0; i < 1000; i++) begin
      ak = busak_n;
      tick_cen();
      if (!ak) acked = 1;
      if (acked && busrq) cnt++;
      if (acked && !busrq) break;
    end
    checks++; if (cnt !== 514) begin errors++; $display("FAIL basic_busrq_len: got %0d expected 514", cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
    commit();
    pulse_vs(); exp_bank = ~exp_bank;
    checks++; if (bank !== exp_bank) begin errors++; $display("FAIL basic_bank: got %b expected %b", bank, exp_bank); end
    read_scan(9'h1FF, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL basic_last_byte: got %0h expected a5", d); end
    for (int a = 0; a < N; a++) begin
      read_scan(9'(a), d);
      if (d !== exp_mem[exp_bank][a]) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_table: got %0d bad bytes expected 0", bad); end
  endtask

  task automatic test_ack_delay();
    bit ok; int bad = 0, stuck = 0; logic [7:0] d;
    fill_vram(1);
    ack_hold = 1'b1;
    pulse_go();
    for (int i = 0; i < 10 && !busrq; i++) tick_cen();
    for (int i = 0; i < 10; i++) begin
      tick_cen();
      if (dma_addr !== 9'd0 || busrq !== 1'b1) stuck++;
    end
    checks++; if (stuck !== 0) begin errors++; $display("FAIL ackdly_hold: got %0d moving cens expected 0", stuck); end
    ack_hold = 1'b0;
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ackdly_done: got %b expected 1", ok); end
    commit();
    pulse_vs(); exp_bank = ~exp_bank;
    checks++; if (bank !== exp_bank) begin errors++; $display("FAIL ackdly_bank: got %b expected %b", bank, exp_bank); end
    for (int a = 0; a < N; a++) begin
      read_scan(9'(a), d);
      if (d !== exp_mem[exp_bank][a]) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ackdly_table: got %0d bad bytes expected 0", bad); end
  endtask

  task automatic test_pause();
    bit ok, found; int bad = 0; logic [7:0] d;
    fill_vram(1);
    pulse_go();
    wait_addr(9'h080, found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL pause_reach: got %b expected 1", found); end
    ack_hold = 1'b1;
    repeat (5) tick_cen();
    ack_hold = 1'b0;
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pause_done: got %b expected 1", ok); end
    commit();
    pulse_vs(); exp_bank = ~exp_bank;
    for (int a = 0; a < N; a++) begin
      read_scan(9'(a), d);
      if (d !== exp_mem[exp_bank][a]) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pause_table: got %0d bad bytes expected 0", bad); end
  endtask

  task automatic test_back_to_back();
    bit found; int rises = 1, falls = 0, gap = 0, quiet = 0, bad = 0;
    logic prev; logic [7:0] d;
    fill_vram(1);
    pulse_go();
    wait_addr(9'h010, found);
    pulse_go();
    repeat (20) tick_cen();
    pulse_go();
    prev = busrq;
    for (int i = 0; i < 3000; i++) begin
      tick_cen();
      vs = 1'b0;
      if (prev && !busrq) begin falls++; commit(); end
      if (!prev && busrq) begin
        rises++;
        // vsync while the second transfer is still in REQ
        if (rises == 2) begin vs = 1'b1; exp_bank = ~exp_bank; end
      end
      if (falls == 1 && rises == 1 && !busrq) gap++;
      if (falls >= 2 && !busy) quiet++;
      if (quiet == 30) break;
      prev = busrq;
    end
    checks++; if (rises !== 2) begin errors++; $display("FAIL b2b_transfers: got %0d expected 2", rises); end
    checks++; if (gap !== 1) begin errors++; $display("FAIL b2b_gap: got %0d expected 1", gap); end
    checks++; if (bank !== exp_bank) begin errors++; $display("FAIL b2b_bank_mid: got %b expected %b", bank, exp_bank); end
    pulse_vs(); exp_bank = ~exp_bank;
    checks++; if (bank !== exp_bank) begin errors++; $display("FAIL b2b_bank_end: got %b expected %b", bank, exp_bank); end
    pulse_vs();
    checks++; if (bank !== exp_bank) begin errors++; $display("FAIL b2b_bank_extra: got %b expected %b", bank, exp_bank); end
    for (int a = 0; a < N; a++) begin
      read_scan(9'(a), d);
      if (d !== exp_mem[exp_bank][a]) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_table: got %0d bad bytes expected 0", bad); end
  endtask

  task automatic test_vs_idle();
    logic [8:0] a, prev_a; logic [7:0] d;
    for (int k = 0; k < 3; k++) begin
      pulse_vs();
      checks++; if (bank !== exp_bank) begin errors++; $display("FAIL vsidle_bank%0d: got %b expected %b", k, bank, exp_bank); end
    end
    prev_a = 9'($urandom_range(0, N - 1));
    read_scan(prev_a, d);
    for (int k = 0; k < 8; k++) begin
      a = 9'($urandom_range(0, N - 1));
      @(negedge clk); scan_addr = a; #1;
      checks++;
      if (scan_dout !== exp_mem[exp_bank][prev_a]) begin
        errors++; $display("FAIL latency_old%0d: got %0h expected %0h", k, scan_dout, exp_mem[exp_bank][prev_a]);
      end
      @(posedge clk); #1;
      checks++;
      if (scan_dout !== exp_mem[exp_bank][a]) begin
        errors++; $display("FAIL latency_new%0d: got %0h expected %0h", k, scan_dout, exp_mem[exp_bank][a]);
      end
      prev_a = a;
    end
  endtask

  task automatic test_reset_mid();
    bit found; int stray = 0;
    fill_vram(1);
    pulse_go();
    wait_addr(9'h100, found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstmid_reach: got %b expected 1", found); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (busrq !== 1'b0) begin errors++; $display("FAIL rstmid_busrq: got %b expected 0", busrq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    @(negedge clk); rst = 1'b0;
    exp_bank = 1'b0;
    pulse_vs();
    checks++; if (bank !== exp_bank) begin errors++; $display("FAIL rstmid_bank: got %b expected %b", bank, exp_bank); end
    for (int i = 0; i < 5; i++) begin
      tick_cen();
      if (busrq !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rstmid_restart: got %0d busrq cens expected 0", stray); end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_pause();
    test_back_to_back();
    test_vs_idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
